// File: rtl/viterbi_pkg.sv
// Definitions shared by the convolutional encoder and the Viterbi decoder:
// code parameters, symbol bit order, encoder FSM states and the parity helper.
package viterbi_pkg;

  localparam int K      = 4;
  localparam int G0_OCT = 'o17;
  localparam int G1_OCT = 'o13;

  localparam int SYM_G0_BIT = 1;
  localparam int SYM_G1_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  // Callers zero-extend a K-bit window and a K-bit truncated generator.
  function automatic logic parity(input logic [31:0] window, input logic [31:0] gen);
    return ^(window & gen);
  endfunction

endpackage

// File: rtl/conv_parity_k.sv
// Combinational map from a K-bit encoder window {u_t, s[K-2:0]} to one coded symbol.
// Also reused by the decoder to form expected branch symbols.
module conv_parity_k
  import viterbi_pkg::*;
#(
  parameter int K      = viterbi_pkg::K,
  parameter int G0_OCT = viterbi_pkg::G0_OCT,
  parameter int G1_OCT = viterbi_pkg::G1_OCT
) (
  input  logic [K-1:0] window,
  output logic [1:0]   sym
);

  localparam logic [K-1:0] G0_MASK = G0_OCT[K-1:0];
  localparam logic [K-1:0] G1_MASK = G1_OCT[K-1:0];

  always_comb begin
    sym             = '0;
    sym[SYM_G0_BIT] = parity(32'(window), 32'(G0_MASK));
    sym[SYM_G1_BIT] = parity(32'(window), 32'(G1_MASK));
  end

endmodule

// File: rtl/conv_encoder_k4.sv
// Rate-1/2 feedforward convolutional encoder with framed input and optional
// zero-tail termination so every frame ends with the trellis in state 0.
module conv_encoder_k4
  import viterbi_pkg::*;
#(
  parameter int K       = viterbi_pkg::K,
  parameter int G0_OCT  = viterbi_pkg::G0_OCT,
  parameter int G1_OCT  = viterbi_pkg::G1_OCT,
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [1:0] sym,
  output logic       sym_tail,
  output logic       sym_last,
  output logic       busy
);

  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;

  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // Once sym_valid is high, sym/sym_tail/sym_last stay stable until sym_ready.
  // in_ready is combinational from sym_ready and never waits on in_valid.

  enc_state_t      state, state_d;
  logic [K-2:0]    sreg, sreg_d;
  logic [TW-1:0]   tail_cnt, tail_d;
  logic            can_load;
  logic            load;
  logic            u;
  logic            tail_flag;
  logic            last_flag;
  logic [K-1:0]    window;
  logic [1:0]      sym_w;

  assign can_load = !sym_valid || sym_ready;
  assign in_ready = can_load && (state != TAIL);
  assign busy     = (state != IDLE) || sym_valid;
  assign window   = {u, sreg};

  conv_parity_k #(
    .K      (K),
    .G0_OCT (G0_OCT),
    .G1_OCT (G1_OCT)
  ) u_parity (
    .window (window),
    .sym    (sym_w)
  );

  always_comb begin
    state_d   = state;
    sreg_d    = sreg;
    tail_d    = tail_cnt;
    load      = 1'b0;
    u         = 1'b0;
    tail_flag = 1'b0;
    last_flag = 1'b0;
    case (state)
      IDLE, DATA: begin
        if (in_valid && can_load) begin
          load    = 1'b1;
          u       = in_bit;
          sreg_d  = {in_bit, sreg[K-2:1]};
          state_d = DATA;
          if (in_last) begin
            if (TAIL_EN) begin
              state_d = TAIL;
            end else begin
              // Truncated frame: no tail, next frame restarts from state 0.
              last_flag = 1'b1;
              sreg_d    = '0;
              state_d   = IDLE;
            end
          end
        end
      end
      TAIL: begin
        if (can_load) begin
          load      = 1'b1;
          tail_flag = 1'b1;
          sreg_d    = {1'b0, sreg[K-2:1]};
          if (tail_cnt == TW'(K - 2)) begin
            last_flag = 1'b1;
            tail_d    = '0;
            state_d   = IDLE;
          end else begin
            tail_d = tail_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      tail_cnt  <= '0;
      sym_valid <= 1'b0;
      sym       <= '0;
      sym_tail  <= 1'b0;
      sym_last  <= 1'b0;
    end else begin
      state    <= state_d;
      sreg     <= sreg_d;
      tail_cnt <= tail_d;
      if (load) begin
        sym_valid <= 1'b1;
        sym       <= sym_w;
        sym_tail  <= tail_flag;
        sym_last  <= last_flag;
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_k4.sv
// Self-checking bench for conv_encoder_k4: directed frames, backpressure,
// back-to-back frames, async reset and randomized traffic against a convolution model.
module tb_conv_encoder_k4;

  localparam int KK = 4;
  localparam int G0_INT = 'o17;
  localparam int G1_INT = 'o13;
  localparam logic [KK-1:0] G0 = G0_INT[KK-1:0];
  localparam logic [KK-1:0] G1 = G1_INT[KK-1:0];

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       sym_valid;
  logic       sym_ready;
  logic [1:0] sym;
  logic       sym_tail;
  logic       sym_last;
  logic       busy;

  conv_encoder_k4 #(.TAIL_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym       (sym),
    .sym_tail  (sym_tail),
    .sym_last  (sym_last),
    .busy      (busy)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_eval = 0;
  int n_fail = 0;

  logic [1:0] bit_q[$];   // {bit, last}
  logic [3:0] exp_q[$];   // {sym[1:0], tail, last}

  int low_cnt;
  int xfer_span;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_eval++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each parity is the GF(2) convolution of the zero-padded bit
  // sequence with the generator taps; tail symbols are inputs beyond the frame.
  task automatic add_frame(input int n, input logic [63:0] pat);
    int total;
    logic p0, p1;
    total = n + KK - 1;
    for (int i = 0; i < n; i++) bit_q.push_back({pat[i], (i == n - 1)});
    for (int t = 0; t < total; t++) begin
      p0 = 1'b0;
      p1 = 1'b0;
      for (int d = 0; d < KK; d++) begin
        if (t - d >= 0 && t - d < n) begin
          p1 = p1 ^ (G0[KK-1-d] & pat[t-d]);
          p0 = p0 ^ (G1[KK-1-d] & pat[t-d]);
        end
      end
      exp_q.push_back({p1, p0, (t >= n), (t == total - 1)});
    end
  endtask

  // driver + scoreboard: one iteration per clock, driven at negedge, sampled #1 later
  task automatic run(input int ready_pct, input int valid_pct,
                     input int stall_at, input int stall_len, input int budget);
    int cyc, xfers, stalled, first, last;
    logic prev_stall;
    logic [3:0] prev_val, e;
    cyc = 0; xfers = 0; stalled = 0; first = -1; last = -1;
    prev_stall = 1'b0; prev_val = '0;
    low_cnt = 0;
    while ((bit_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      if (bit_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        {in_bit, in_last} = bit_q[0];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
      end
      if (xfers == stall_at && stalled < stall_len) begin
        sym_ready = 1'b0;
        stalled++;
      end else begin
        sym_ready = ($urandom_range(99) < ready_pct);
      end
      #1;
      if (!in_ready) low_cnt++;
      if (prev_stall) begin
        check("hold_valid", 8'(sym_valid), 8'd1);
        check("hold_data", 8'({sym, sym_tail, sym_last}), 8'(prev_val));
      end
      if (sym_valid) check("busy_active", 8'(busy), 8'd1);
      if (sym_valid && !sym_ready) check("in_ready_stall", 8'(in_ready), 8'd0);
      if (in_valid && in_ready) void'(bit_q.pop_front());
      if (sym_valid && sym_ready) begin
        check("sym_expected", 8'(exp_q.size() > 0), 8'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sym", 8'({sym, sym_tail, sym_last}), 8'(e));
        end
        if (first < 0) first = cyc;
        last = cyc;
        xfers++;
      end
      prev_stall = sym_valid && !sym_ready;
      prev_val   = {sym, sym_tail, sym_last};
      cyc++;
    end
    check("run_drained", 8'(bit_q.size() + exp_q.size()), 8'd0);
    bit_q.delete();
    exp_q.delete();
    xfer_span = last - first + 1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    sym_ready = 1'b1;
    #1;
    check("idle_busy", 8'(busy), 8'd0);
    check("idle_sym_valid", 8'(sym_valid), 8'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    sym_ready = 1'b0;

    @(negedge clk);
    #1;
    check("rst_sym_valid", 8'(sym_valid), 8'd0);
    check("rst_sym", 8'(sym), 8'd0);
    check("rst_sym_tail", 8'(sym_tail), 8'd0);
    check("rst_sym_last", 8'(sym_last), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 8'(in_ready), 8'd1);

    // impulse: 11,10,11,11
    add_frame(1, 64'h1);
    run(100, 100, -1, 0, 200);
    check("impulse_span", 8'(xfer_span), 8'd4);

    // {1,1}: 11,01,01,00,11
    add_frame(2, 64'h3);
    run(100, 100, -1, 0, 200);

    // all-zero 8-bit frame: 11 zero symbols
    add_frame(8, 64'h0);
    run(100, 100, -1, 0, 200);
    check("zero_span", 8'(xfer_span), 8'd11);

    // backpressure: 3-cycle stall on the 2nd symbol
    add_frame(1, 64'h1);
    run(100, 100, 1, 3, 200);
    check("stall_span", 8'(xfer_span), 8'd7);

    // back-to-back frames {1} then {1,1}
    add_frame(1, 64'h1);
    add_frame(2, 64'h3);
    run(100, 100, -1, 0, 200);
    check("b2b_span", 8'(xfer_span), 8'd9);
    check("b2b_in_ready_low", 8'(low_cnt), 8'd6);

    // async reset between the 2nd and 3rd bits of a frame
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0; sym_ready = 1'b1;
    @(negedge clk);
    in_bit = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_bit = 1'b0;
    #1;
    check("pre_rst_sym_valid", 8'(sym_valid), 8'd1);
    check("pre_rst_busy", 8'(busy), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_sym_valid", 8'(sym_valid), 8'd0);
    check("async_sym", 8'(sym), 8'd0);
    check("async_sym_tail", 8'(sym_tail), 8'd0);
    check("async_sym_last", 8'(sym_last), 8'd0);
    check("async_busy", 8'(busy), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 8'(in_ready), 8'd1);
    add_frame(1, 64'h1);
    run(100, 100, -1, 0, 200);
    check("post_rst_span", 8'(xfer_span), 8'd4);

    // randomized frames with random valid gaps and backpressure
    for (int f = 0; f < 12; f++) begin
      add_frame($urandom_range(40, 1), {$urandom, $urandom});
      if (f % 3 == 2) run($urandom_range(100, 30), $urandom_range(100, 30), -1, 0, 5000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_encoder_k4.md
Name: conv_encoder_k4

Overview:
- Rate-1/2 feedforward convolutional encoder sitting directly upstream of the Viterbi decoder core.
- Accepts a framed information-bit stream with a valid/ready handshake.
- Emits one 2-bit coded symbol per accepted bit. At frame end it appends K-1 zero tail bits so the trellis terminates in state 0.
- Drives the decoder's symbol interface, and its tail-forcing control, directly; also used as the stimulus source in benches.

Parameters:
- K, 4, constraint length; shift register holds K-1 past bits.
- G0_OCT, 'o17, generator for sym[1]; bit K-1 taps current input, bit 0 taps oldest bit.
- G1_OCT, 'o13, generator for sym[0]; same tap convention.
- TAIL_EN, 1, 1 appends K-1 zero tail symbols after in_last; 0 means no tail (truncated mode).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  information bit valid
- in_ready  out  1  encoder can accept a bit this cycle
- in_bit  in  1  information bit
- in_last  in  1  marks last information bit of frame; qualified by in_valid
- sym_valid  out  1  coded symbol valid (connects to decoder rx_sym_valid)
- sym_ready  in  1  downstream accepts symbol (from decoder rx_sym_ready)
- sym  out  2  coded symbol: sym[1]=G0 parity, sym[0]=G1 parity
- sym_tail  out  1  current symbol is a tail symbol (drives decoder force_state0)
- sym_last  out  1  current symbol is the final symbol of the frame
- busy  out  1  frame in progress (state != IDLE, or sym_valid high)

Behaviour:
- Reset (asynchronous, immediate) values:
  - sym_valid=0, sym=00, sym_tail=0, sym_last=0, busy=0
  - shift register all zero, tail counter 0, FSM in IDLE
  - in_ready=1 once rst deasserts
- Window w = {u_t, s[K-2:0]}, where s[K-2] is the newest past bit.
- Parities:
  - sym[1] = ^(w & G0_OCT)
  - sym[0] = ^(w & G1_OCT)
  - All widths are K bits; generators are truncated to K bits.
- Output register:
  - sym/sym_valid/sym_tail/sym_last are registered.
  - A load occurs when (!sym_valid || sym_ready) and a symbol source is available.
  - Latency: an accepted bit appears on sym the next cycle.
  - Sustained throughput: 1 symbol/cycle while sym_ready=1.
- Hold rule: while sym_valid=1 and sym_ready=0, sym, sym_tail and sym_last are held stable.
- Dequeue: when sym_ready=1 and no new load occurs, sym_valid drops to 0 in the following cycle.
- in_ready = (!sym_valid || sym_ready) && state != TAIL. Combinational; depends on sym_ready.
- FSM:
  - IDLE: on bit accept, load symbol, shift in u, go to DATA. If in_last and TAIL_EN, go directly to TAIL.
  - IDLE, truncated case (in_last with TAIL_EN=0): set sym_last=1, clear the shift register after load, stay in IDLE.
  - DATA: each accept loads a symbol and shifts. On in_last: go to TAIL if TAIL_EN; otherwise set sym_last, clear the shift register, go to IDLE.
  - TAIL: each load slot encodes u=0 with sym_tail=1 and increments tail_cnt.
  - TAIL exit: the (K-1)th tail symbol carries sym_last=1. Then the shift register is all zero and the FSM returns to IDLE.
- Input is not accepted during TAIL; any in_valid is left pending.
- Back-to-back frames: the first bit of the next frame is accepted in the cycle the last tail symbol is consumed. No bubble is required beyond the in_ready rule.
- busy=1 from the first accept until the sym_last symbol has been consumed.
- Reset mid-frame: all state is discarded with no partial tail emitted; the next frame starts from state 0.
- Single-bit frame (in_last on the first bit) is legal: 1 data symbol plus K-1 tail symbols.

Decomposition:
- Shared package viterbi_pkg holds:
  - K, G0_OCT, G1_OCT defaults, shared with the decoder
  - symbol bit-order constants SYM_G0_BIT=1, SYM_G1_BIT=0
  - FSM state enum {IDLE, DATA, TAIL}
  - function parity(window, gen)
- One natural sub-module: conv_parity_k, a combinational window-to-2-bit-symbol encoder. The decoder's branch-metric expected-symbol logic reuses it.

Test Plan:
- Impulse: frame {1} with in_last, sym_ready=1 -> symbols 11,10,11,11; sym_tail=0,1,1,1; sym_last only on the 4th symbol.
- Frame {1,1}, last on the 2nd bit -> symbols 11,01,01,00,11; sym_tail on the last 3; shift register zero afterwards.
- All-zero 8-bit frame -> 11 symbols, all 00; busy falls the cycle after the sym_last symbol is consumed.
- Backpressure:
  - Stimulus: frame {1}; sym_ready=0 for 3 cycles on the 2nd symbol.
  - Response: sym stays 10 with sym_valid=1 throughout the stall; in_ready=0; no symbol lost or duplicated; sequence still 11,10,11,11.
- Back-to-back frames {1} then {1,1} with in_valid held high -> 9 contiguous symbols 11,10,11,11,11,01,01,00,11; in_ready low exactly during the tail cycles.
- Async reset asserted mid-frame (between the 2nd and 3rd bits) -> outputs clear immediately, without waiting for a clock edge; a new frame {1} then yields 11,10,11,11.
- Loopback: a random 200-bit frame through the decoder core (D=24) -> the decoded bits equal the input.
